// File: rtl/intc_pkg.sv
// ---------------------------------------------------------------------------
// intc_pkg
// Shared definitions for the CPU-side interrupt sequencer:
//   state_e         - sequencer FSM states (IDLE, ACK, ENTER, ISR, EXIT)
//   ADDR_W_DEF      - default PC width
//   RESET_IE_DEF    - default interrupt-enable value after reset
//   HOLDOFF_DEF     - default commits required after eret before re-entry
// ---------------------------------------------------------------------------
package intc_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ACK   = 3'd1,
        ENTER = 3'd2,
        ISR   = 3'd3,
        EXIT  = 3'd4
    } state_e;

    localparam int   ADDR_W_DEF   = 32;
    localparam logic RESET_IE_DEF = 1'b1;
    localparam int   HOLDOFF_DEF  = 1;

endpackage

// File: rtl/irq_sequencer_if.sv
// ---------------------------------------------------------------------------
// irq_sequencer_if
// Request/acknowledge link between the interrupt controller and the CPU-side
// sequencer.
//   irq        - level request, held by the controller until serviced
//   pc_handler - handler address, meaningful while irq==1
//   iack       - one-cycle acknowledge pulse from the sequencer
// Handshake: the controller holds irq and pc_handler stable until it sees
// iack==1 for one cycle; the sequencer samples pc_handler only on the edge
// where it decides to take the interrupt, and pulses iack exactly once per
// taken interrupt, on the cycle after that decision.
// Modports:
//   master - controller side (drives irq/pc_handler, receives iack)
//   slave  - sequencer side (receives irq/pc_handler, drives iack)
// ---------------------------------------------------------------------------
interface irq_sequencer_if #(
    parameter int ADDR_W = 32
);
    logic              irq;
    logic [ADDR_W-1:0] pc_handler;
    logic              iack;

    modport master (
        output irq,
        output pc_handler,
        input  iack
    );

    modport slave (
        input  irq,
        input  pc_handler,
        output iack
    );
endinterface

// File: rtl/irq_sequencer.sv
// ---------------------------------------------------------------------------
// irq_sequencer
// Takes interrupts at instruction boundaries, saves the return PC, pulses
// iack to the controller, then redirects fetch to the handler. On eret it
// redirects fetch back to epc and restores the interrupt-enable bit.
// Ports:
//   clk, rst        - clock; synchronous active-low reset
//   ctl             - controller link (irq, pc_handler in; iack out)
//   pc_current      - PC of next instruction, valid when commit==1
//   commit          - instruction boundary; redirect accepted this cycle
//   eret            - return-from-interrupt pulse
//   ie_wr/ie_wdata  - software write of the interrupt-enable bit
//   pc_redirect     - one-cycle pulse: fetch loads pc_target
//   pc_target       - redirect address (0 when no redirect)
//   epc             - saved return PC
//   in_isr          - high from entry until the eret redirect
//   ie              - current interrupt-enable bit
//   dbg_state       - current FSM state, for observation only
// ---------------------------------------------------------------------------
module irq_sequencer
    import intc_pkg::*;
#(
    parameter int   ADDR_W   = ADDR_W_DEF,
    parameter logic RESET_IE = RESET_IE_DEF,
    parameter int   HOLDOFF  = HOLDOFF_DEF
) (
    input  logic              clk,
    input  logic              rst,
    irq_sequencer_if.slave    ctl,
    input  logic [ADDR_W-1:0] pc_current,
    input  logic              commit,
    input  logic              eret,
    input  logic              ie_wr,
    input  logic              ie_wdata,
    output logic              pc_redirect,
    output logic [ADDR_W-1:0] pc_target,
    output logic [ADDR_W-1:0] epc,
    output logic              in_isr,
    output logic              ie,
    output state_e            dbg_state
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] epc_q, epc_d;
    logic [ADDR_W-1:0] handler_q, handler_d;
    logic              pie_q, pie_d;
    logic              ie_q, ie_d;
    logic              in_isr_q, in_isr_d;
    logic [3:0]        holdoff_q, holdoff_d;
    logic              iack_c;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            epc_q     <= '0;
            handler_q <= '0;
            pie_q     <= 1'b0;
            ie_q      <= RESET_IE;
            in_isr_q  <= 1'b0;
            holdoff_q <= 4'd0;
        end else begin
            state_q   <= state_d;
            epc_q     <= epc_d;
            handler_q <= handler_d;
            pie_q     <= pie_d;
            ie_q      <= ie_d;
            in_isr_q  <= in_isr_d;
            holdoff_q <= holdoff_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        epc_d       = epc_q;
        handler_d   = handler_q;
        pie_d       = pie_q;
        ie_d        = ie_q;
        in_isr_d    = in_isr_q;
        holdoff_d   = holdoff_q;
        iack_c      = 1'b0;
        pc_redirect = 1'b0;
        pc_target   = '0;

        // Holdoff counts committed instructions down to zero; EXIT reloads it.
        if (commit && (holdoff_q != 4'd0)) begin
            holdoff_d = holdoff_q - 4'd1;
        end

        unique case (state_q)
            IDLE: begin
                if (ie_wr) begin
                    ie_d = ie_wdata;
                end
                // Decision uses the registered ie so a same-cycle write
                // cannot open or close the window early.
                if (ctl.irq && ie_q && commit && (holdoff_q == 4'd0)) begin
                    epc_d     = pc_current;
                    handler_d = ctl.pc_handler;
                    pie_d     = ie_q;
                    state_d   = ACK;
                end
            end
            ACK: begin
                iack_c   = 1'b1;
                ie_d     = 1'b0;   // masking beats any software write here
                in_isr_d = 1'b1;
                state_d  = ENTER;
            end
            ENTER: begin
                pc_redirect = 1'b1;
                pc_target   = handler_q;
                if (ie_wr) begin
                    ie_d = ie_wdata;
                end
                state_d = ISR;
            end
            ISR: begin
                // Inside the handler, software writes target the value to be
                // restored on return; a same-cycle eret sees the new value.
                if (ie_wr) begin
                    pie_d = ie_wdata;
                end
                if (eret) begin
                    state_d = EXIT;
                end
            end
            EXIT: begin
                pc_redirect = 1'b1;
                pc_target   = epc_q;
                ie_d        = pie_q;
                in_isr_d    = 1'b0;
                holdoff_d   = 4'(HOLDOFF);
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ctl.iack  = iack_c;
    assign epc       = epc_q;
    assign in_isr    = in_isr_q;
    assign ie        = ie_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_irq_sequencer.sv
// ---------------------------------------------------------------------------
// tb_irq_sequencer
// Directed scenarios followed by randomized traffic. A timeline reference
// model, driven by edge counts since entry/eret, predicts every output each
// cycle; directed steps add fixed-value checks on top.
// ---------------------------------------------------------------------------
module tb_irq_sequencer;
    import intc_pkg::*;

    localparam int   AW  = 32;
    localparam logic RIE = 1'b1;
    localparam int   HO  = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [AW-1:0] pc_current;
    logic          commit;
    logic          eret;
    logic          ie_wr;
    logic          ie_wdata;
    logic          pc_redirect;
    logic [AW-1:0] pc_target;
    logic [AW-1:0] epc;
    logic          in_isr;
    logic          ie;
    state_e        dbg_state;

    irq_sequencer_if #(.ADDR_W(AW)) ctl_if ();

    irq_sequencer #(.ADDR_W(AW), .RESET_IE(RIE), .HOLDOFF(HO)) dut (
        .clk        (clk),
        .rst        (rst),
        .ctl        (ctl_if),
        .pc_current (pc_current),
        .commit     (commit),
        .eret       (eret),
        .ie_wr      (ie_wr),
        .ie_wdata   (ie_wdata),
        .pc_redirect(pc_redirect),
        .pc_target  (pc_target),
        .epc        (epc),
        .in_isr     (in_isr),
        .ie         (ie),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cnt_iack = 0;
    int cnt_redir = 0;

    // Reference model: what software/hardware contract says, tracked by edge
    // distance from the interrupt being taken and from eret.
    int            cyc = 0;
    int            entry_edge = -100;
    bit            m_busy = 0;
    bit            m_exiting = 0;
    bit            m_ie = RIE;
    bit            m_pie = 0;
    bit            m_isr = 0;
    int            m_hold = 0;
    logic [AW-1:0] m_epc = '0;
    logic [AW-1:0] m_handler = '0;
    bit            e_iack = 0;
    bit            e_redir = 0;
    logic [AW-1:0] e_target = '0;

    task automatic chk(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit take;
        bit old_ie;
        cyc++;
        e_iack   = 0;
        e_redir  = 0;
        e_target = '0;
        if (!rst) begin
            m_busy = 0; m_exiting = 0; m_ie = RIE; m_pie = 0; m_isr = 0;
            m_hold = 0; m_epc = '0; m_handler = '0;
            return;
        end
        if (!m_busy) begin
            old_ie = m_ie;
            take = ctl_if.irq && old_ie && commit && (m_hold == 0);
            if (commit && m_hold > 0) m_hold--;
            if (ie_wr) m_ie = ie_wdata;
            if (take) begin
                m_busy     = 1;
                entry_edge = cyc;
                m_epc      = pc_current;
                m_handler  = ctl_if.pc_handler;
                m_pie      = old_ie;
                e_iack     = 1;
            end
        end else if (m_exiting) begin
            m_ie = m_pie; m_isr = 0; m_hold = HO; m_busy = 0; m_exiting = 0;
        end else begin
            if (commit && m_hold > 0) m_hold--;
            case (cyc - entry_edge)
                1: begin
                    m_ie = 0; m_isr = 1; e_redir = 1; e_target = m_handler;
                end
                2: if (ie_wr) m_ie = ie_wdata;
                default: begin
                    if (ie_wr) m_pie = ie_wdata;
                    if (eret) begin
                        m_exiting = 1; e_redir = 1; e_target = m_epc;
                    end
                end
            endcase
        end
    endtask

    task automatic check_outputs();
        if (ctl_if.iack === 1'b1) cnt_iack++;
        if (pc_redirect === 1'b1) cnt_redir++;
        chk($sformatf("iack@%0d", cyc),        AW'(ctl_if.iack), AW'(e_iack));
        chk($sformatf("pc_redirect@%0d", cyc), AW'(pc_redirect), AW'(e_redir));
        chk($sformatf("pc_target@%0d", cyc),   pc_target, e_target);
        chk($sformatf("epc@%0d", cyc),         epc, m_epc);
        chk($sformatf("in_isr@%0d", cyc),      AW'(in_isr), AW'(m_isr));
        chk($sformatf("ie@%0d", cyc),          AW'(ie), AW'(m_ie));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic set_in(input bit irq_v, input bit commit_v, input logic [AW-1:0] pc_v,
                          input bit eret_v, input bit iew, input bit iewd);
        ctl_if.irq = irq_v;
        commit     = commit_v;
        pc_current = pc_v;
        eret       = eret_v;
        ie_wr      = iew;
        ie_wdata   = iewd;
    endtask

    // From the iack cycle: walk through ENTER/ISR, return, settle in IDLE.
    task automatic finish_isr();
        set_in(0, 0, 32'h0, 0, 0, 0);
        step();
        step();
        set_in(0, 0, 32'h0, 1, 0, 0);
        step();
        set_in(0, 0, 32'h0, 0, 0, 0);
        step();
    endtask

    initial begin
        ctl_if.pc_handler = 32'h0000_0100;
        set_in(0, 0, 32'h0, 0, 0, 0);

        // Reset
        rst = 1'b0;
        step();
        step();
        chk("reset_iack", AW'(ctl_if.iack), '0);
        chk("reset_redir", AW'(pc_redirect), '0);
        chk("reset_ie", AW'(ie), AW'(RIE));
        chk("reset_state", AW'(dbg_state), AW'(IDLE));
        rst = 1'b1;
        step();

        // Basic entry
        set_in(1, 1, 32'h0000_0040, 0, 0, 0);
        step();
        chk("basic_iack", AW'(ctl_if.iack), 32'd1);
        set_in(0, 0, 32'h0, 0, 0, 0);
        step();
        chk("basic_redir", AW'(pc_redirect), 32'd1);
        chk("basic_target", pc_target, 32'h100);
        chk("basic_epc", epc, 32'h40);
        chk("basic_in_isr", AW'(in_isr), 32'd1);
        chk("basic_ie", AW'(ie), 32'd0);
        step();

        // Return and holdoff
        set_in(0, 0, 32'h0, 1, 0, 0);
        step();
        chk("ret_redir", AW'(pc_redirect), 32'd1);
        chk("ret_target", pc_target, 32'h40);
        set_in(0, 0, 32'h0, 0, 0, 0);
        step();
        chk("ret_in_isr", AW'(in_isr), 32'd0);
        chk("ret_ie", AW'(ie), 32'd1);
        set_in(1, 1, 32'h44, 0, 0, 0);
        step();
        chk("holdoff_blocks", AW'(ctl_if.iack), 32'd0);
        step();
        chk("holdoff_expired", AW'(ctl_if.iack), 32'd1);
        finish_isr();

        // Masking
        set_in(0, 0, 32'h0, 0, 1, 0);
        step();
        cnt_iack = 0; cnt_redir = 0;
        set_in(1, 1, 32'h50, 0, 0, 0);
        repeat (5) step();
        chk("mask_iack_cnt", AW'(cnt_iack), 32'd0);
        chk("mask_redir_cnt", AW'(cnt_redir), 32'd0);
        set_in(1, 1, 32'h54, 0, 1, 1);
        step();
        chk("unmask_same_edge", AW'(ctl_if.iack), 32'd0);
        set_in(1, 1, 32'h58, 0, 0, 0);
        step();
        chk("unmask_entry", AW'(ctl_if.iack), 32'd1);
        finish_isr();

        // Boundary wait
        set_in(0, 1, 32'h0, 0, 0, 0);
        step();
        cnt_iack = 0;
        set_in(1, 0, 32'h0, 0, 0, 0);
        repeat (4) step();
        set_in(1, 1, 32'h80, 0, 0, 0);
        step();
        finish_isr();
        chk("wait_one_iack", AW'(cnt_iack), 32'd1);
        chk("wait_epc", epc, 32'h80);
        set_in(0, 1, 32'h0, 0, 0, 0);
        step();
        cnt_iack = 0;
        set_in(1, 0, 32'h0, 0, 0, 0);
        repeat (2) step();
        set_in(0, 1, 32'h84, 0, 0, 0);
        repeat (2) step();
        chk("drop_no_iack", AW'(cnt_iack), 32'd0);

        // No nesting, pie write inside ISR
        cnt_iack = 0;
        set_in(1, 1, 32'h90, 0, 0, 0);
        step();
        set_in(1, 0, 32'h0, 0, 1, 0);
        repeat (4) step();
        chk("nest_one_iack", AW'(cnt_iack), 32'd1);
        set_in(1, 0, 32'h0, 1, 1, 0);
        step();
        set_in(1, 1, 32'h94, 0, 0, 0);
        repeat (5) step();
        chk("pie_ie_off", AW'(ie), 32'd0);
        chk("pie_no_reentry", AW'(cnt_iack), 32'd1);
        set_in(0, 0, 32'h0, 0, 1, 1);
        step();

        // Reset in the ACK cycle
        ctl_if.pc_handler = 32'h0000_0200;
        set_in(1, 1, 32'hA0, 0, 0, 0);
        step();
        chk("rst_mid_iack_pre", AW'(ctl_if.iack), 32'd1);
        rst = 1'b0;
        set_in(0, 0, 32'h0, 0, 0, 0);
        step();
        chk("rst_mid_iack", AW'(ctl_if.iack), 32'd0);
        chk("rst_mid_redir", AW'(pc_redirect), 32'd0);
        chk("rst_mid_epc", epc, 32'h0);
        chk("rst_mid_in_isr", AW'(in_isr), 32'd0);
        chk("rst_mid_ie", AW'(ie), AW'(RIE));
        chk("rst_mid_state", AW'(dbg_state), AW'(IDLE));
        rst = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            ctl_if.pc_handler = $urandom();
            set_in($urandom_range(0, 1) == 1, $urandom_range(0, 9) < 6, $urandom(),
                   $urandom_range(0, 9) < 2, $urandom_range(0, 9) == 0,
                   $urandom_range(0, 2) != 0);
            rst = ($urandom_range(0, 99) != 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
